// File: rtl/jk_ctrl_pkg.sv
// Op codes and FSM state encodings shared by the JK bank sequencer and its step generator.
// No logic, no latency, no flow control: constants and types only.
package jk_ctrl_pkg;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_INC    = 3'b100;
    localparam logic [2:0] OP_DEC    = 3'b101;
    localparam logic [2:0] OP_ROTL   = 3'b110;
    localparam logic [2:0] OP_RSVD   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/jk_step_gen.sv
// Per-cycle J/K vector for one step of the latched op, derived from the live bank Q.
// Purely combinational (zero latency); outputs all-zero when not enabled, no flow control.
module jk_step_gen
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k
);

    logic [WIDTH-1:0] w_inc_t;
    logic [WIDTH-1:0] w_dec_t;
    logic [WIDTH-1:0] w_rot;

    // Bit i toggles when every lower bit is 1 (count up) or 0 (count down).
    always_comb begin
        w_inc_t = '0;
        w_dec_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            logic [WIDTH-1:0] m;
            m          = (WIDTH'(1) << i) - WIDTH'(1);
            w_inc_t[i] = &(i_q | ~m);
            w_dec_t[i] = ~|(i_q & m);
        end
    end

    assign w_rot = {i_q[WIDTH-2:0], i_q[WIDTH-1]};

    always_comb begin
        o_j = '0;
        o_k = '0;
        if (i_en) begin
            case (i_op)
                OP_CLEAR:  begin o_j = '0;      o_k = '1;      end
                OP_LOAD:   begin o_j = i_data;  o_k = ~i_data; end
                OP_TOGGLE: begin o_j = i_data;  o_k = i_data;  end
                OP_INC:    begin o_j = w_inc_t; o_k = w_inc_t; end
                OP_DEC:    begin o_j = w_dec_t; o_k = w_dec_t; end
                OP_ROTL:   begin o_j = w_rot;   o_k = ~w_rot;  end
                default:   begin o_j = '0;      o_k = '0;      end
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command sequencer driving J/K vectors into an external JK bank, one step per cycle.
// N-step op accepted at edge t: steps t+1..t+N, done t+N+1, ready t+N+2; holds cmd_ready low while busy.
module jk_bank_sequencer
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_steps_left;
    logic             w_accept;
    logic             w_single;
    logic             w_zero_step;
    logic             w_step_en;

    assign cmd_ready = reset && (r_state == ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_single  = (cmd_op == OP_CLEAR) || (cmd_op == OP_LOAD) || (cmd_op == OP_TOGGLE);
    // Ops with nothing to drive skip EXEC entirely and report straight away.
    assign w_zero_step = (cmd_op == OP_NOP) || (cmd_op == OP_RSVD) ||
                         (!w_single && (cmd_count == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero_step ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (abort || (r_steps_left == CNT_W'(1))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op         <= OP_NOP;
            r_data       <= '0;
            r_steps_left <= '0;
        end else if (w_accept) begin
            r_op         <= cmd_op;
            r_data       <= cmd_data;
            r_steps_left <= w_single ? CNT_W'(1) : cmd_count;
        end else if (r_state == ST_EXEC) begin
            r_steps_left <= r_steps_left - CNT_W'(1);
        end
    end

    // An aborting cycle drives no step into the bank.
    assign w_step_en = (r_state == ST_EXEC) && !abort;

    jk_step_gen #(.WIDTH(WIDTH)) u_step_gen (
        .i_op   (r_op),
        .i_data (r_data),
        .i_q    (q_in),
        .i_en   (w_step_en),
        .o_j    (j_out),
        .o_k    (k_out)
    );

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign err  = done && (r_op == OP_RSVD);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench: sequencer driving a behavioural 8-bit JK bank whose Q feeds back to q_in.
module tb_jk_bank_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] cmd_count;
    logic       abort;
    logic [7:0] j_out;
    logic [7:0] k_out;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] bank_q;
    logic       preset_en;
    logic [7:0] preset_val;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    jk_bank_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .abort     (abort),
        .q_in      (bank_q),
        .j_out     (j_out),
        .k_out     (k_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // External JK bank (not reset by the sequencer); preset port lets the bench seed Q.
    always @(posedge clk) begin
        if (preset_en) begin
            bank_q <= preset_val;
        end else begin
            for (int b = 0; b < 8; b++) begin
                case ({j_out[b], k_out[b]})
                    2'b10:   bank_q[b] <= 1'b1;
                    2'b01:   bank_q[b] <= 1'b0;
                    2'b11:   bank_q[b] <= ~bank_q[b];
                    default: bank_q[b] <= bank_q[b];
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic preset(input logic [7:0] v);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    // Returns at cycle t+1 (accept edge t), 1 ns after the falling edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] data, input logic [7:0] count);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = count;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'b000;
        cmd_data   = 8'h00;
        cmd_count  = 8'h00;
        abort      = 1'b0;
        preset_en  = 1'b1;
        preset_val = 8'h00;
        #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_err",   err, 0);
        chk("rst_j",     j_out, 0);
        chk("rst_k",     k_out, 0);
        nxt();
        nxt();
        reset     = 1'b1;
        preset_en = 1'b0;
        #1;
        chk("rel_ready", cmd_ready, 1);

        // LOAD A5 from 00
        preset(8'h00);
        issue(3'b010, 8'hA5, 8'h00);
        chk("load_j", j_out, 8'hA5);
        chk("load_k", k_out, 8'h5A);
        chk("load_busy", busy, 1);
        chk("load_ready_t1", cmd_ready, 0);
        nxt();
        chk("load_q", bank_q, 8'hA5);
        chk("load_j_t2", j_out, 0);
        chk("load_done", done, 1);
        chk("load_ready_t2", cmd_ready, 0);
        nxt();
        chk("load_ready_t3", cmd_ready, 1);
        chk("load_done_t3", done, 0);

        // INC 3 from FE, with a CLEAR offered while busy that must be ignored
        preset(8'hFE);
        issue(3'b100, 8'h00, 8'd3);
        chk("inc_jk1", j_out, 8'h01);
        chk("inc_k1", k_out, 8'h01);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'b001;
        #1;
        chk("inc_q1", bank_q, 8'hFF);
        chk("inc_jk2", j_out, 8'hFF);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("inc_q2", bank_q, 8'h00);
        chk("inc_jk3", j_out, 8'h01);
        chk("inc_done_t3", done, 0);
        nxt();
        chk("inc_q3", bank_q, 8'h01);
        chk("inc_done", done, 1);
        nxt();
        chk("inc_idle", busy, 0);
        chk("inc_q_hold", bank_q, 8'h01);

        // DEC 1 from 00
        preset(8'h00);
        issue(3'b101, 8'h00, 8'd1);
        chk("dec_j", j_out, 8'hFF);
        chk("dec_k", k_out, 8'hFF);
        nxt();
        chk("dec_q", bank_q, 8'hFF);
        chk("dec_done", done, 1);

        // ROTL 2 from 81
        preset(8'h81);
        issue(3'b110, 8'h00, 8'd2);
        chk("rot_j1", j_out, 8'h03);
        chk("rot_k1", k_out, 8'hFC);
        nxt();
        chk("rot_q1", bank_q, 8'h03);
        chk("rot_done_t2", done, 0);
        nxt();
        chk("rot_q2", bank_q, 8'h06);
        chk("rot_done", done, 1);

        // Reserved op: straight to DONE with err
        issue(3'b111, 8'hFF, 8'd5);
        chk("rsvd_done", done, 1);
        chk("rsvd_err", err, 1);
        chk("rsvd_j", j_out, 0);
        chk("rsvd_q", bank_q, 8'h06);
        nxt();
        chk("rsvd_err_off", err, 0);
        chk("rsvd_ready", cmd_ready, 1);

        // INC with zero count: done without err or step
        issue(3'b100, 8'h00, 8'd0);
        chk("inc0_done", done, 1);
        chk("inc0_err", err, 0);
        chk("inc0_j", j_out, 0);
        nxt();
        chk("inc0_q", bank_q, 8'h06);

        // INC 10 from 00, aborted in third EXEC cycle
        preset(8'h00);
        issue(3'b100, 8'h00, 8'd10);
        chk("ab_j1", j_out, 8'h01);
        nxt();
        chk("ab_j2", j_out, 8'h03);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("ab_j3", j_out, 0);
        chk("ab_k3", k_out, 0);
        chk("ab_done_t3", done, 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("ab_q", bank_q, 8'h02);
        chk("ab_done", done, 1);
        chk("ab_err", err, 0);
        nxt();
        chk("ab_ready", cmd_ready, 1);

        // Same run, reset asserted at the third EXEC cycle instead
        preset(8'h00);
        issue(3'b100, 8'h00, 8'd10);
        nxt();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rab_j", j_out, 0);
        chk("rab_k", k_out, 0);
        chk("rab_done", done, 0);
        chk("rab_busy", busy, 0);
        chk("rab_ready_low", cmd_ready, 0);
        nxt();
        chk("rab_q", bank_q, 8'h02);
        chk("rab_done2", done, 0);
        reset = 1'b1;
        #1;
        chk("rab_ready", cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
